mux_tree_pipe: RTL
==================

Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 word multiplexer built as a radix-4 tree. Each tree level resolves 2 select bits and is followed by a register stage.
- Select travels with the data. Valid/ready handshake on both sides, with full backpressure.
- Sits between wide multi-source datapaths and a single consumer. It is the scalable successor to the fixed 16:1 bit mux.

Parameters:
- NUM_IN, 16, number of input words; power of 2, range 2..256.
- DATA_W, 8, width of each input word and of the output.
- SEL_W, $clog2(NUM_IN), select width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*DATA_W  flattened inputs; word k = in_data[k*DATA_W +: DATA_W].
- in_sel  input  SEL_W  index of the word to forward.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  block accepts the transfer this cycle.
- out_data  output  DATA_W  selected word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Structure:
  - L = SEL_W levels of 2:1 selection, grouped into S = ceil(L/2) stages.
  - Stage j uses in_sel bits [2j+1:2j]. If L is odd, the last stage is 2:1 and uses only bit L-1.
  - Stage 0 takes in_data directly.
- Per-stage registers: partial words (NUM_IN/4^(j+1), rounded up, words of DATA_W), the remaining unused select bits, and a valid bit v_j.
- Accept: a transfer occurs when in_valid && in_ready. in_data and in_sel are sampled on the same edge.
- Latency: exactly S cycles from accept to out_valid when out_ready is held high.
  - NUM_IN=16 gives S=2; NUM_IN=2 gives S=1; NUM_IN=32 gives S=3.
- Throughput: one word per cycle with out_ready high.
- Stage ready (bubble collapsing):
  - rdy_S = out_ready.
  - rdy_j = !v_j || rdy_{j+1}.
  - in_ready = rdy_0. This is a combinational path from out_ready; it is accepted.
- Stage advance: on the clock edge, stage j loads from stage j-1 when rdy_j.
  - v_j takes v_{j-1}; stage 0 takes in_valid && in_ready.
  - When !rdy_j, data, select and v_j hold.
- Output: out_data and out_valid are the final-stage registers. out_data must remain stable while out_valid && !out_ready.
- Order and loss: no drop, no duplication, strict FIFO order. Capacity is S in-flight words.
- Bubbles: an empty stage is overwritten even when downstream stalls, so a gap between inputs is absorbed.
- Select range: every in_sel value selects a valid word; there is no out-of-range case.
- Reset (async assert, mid-operation included):
  - all v_j = 0, out_valid = 0, out_data = 0, stage data = 0.
  - In-flight words are discarded.
  - in_ready = 1 while out_ready = 1 or the pipe is empty. During reset it is 1, since all stages are empty.
- Reset release: deassertion is synchronised externally. The first accept is possible on the first edge after release.
- Data when idle: data registers may load while v = 0 (don't-care). Bench checks out_data only when out_valid = 1.

Optional Feature:
- Macro: MUX_TREE_PIPE_SEL_ECHO_EN.
- Defined:
  - Adds output port out_sel, SEL_W bits.
  - The full original in_sel is carried through every stage alongside the data.
  - out_sel updates with out_data, holds under stall, and resets to 0.
- Undefined:
  - Port is absent.
  - Stages carry only the select bits still needed, which shrink by 2 per stage.

Test Plan:
- NUM_IN=16, DATA_W=8, word k=8'h10+k. Hold out_ready=1 and sweep in_sel 0..15 back-to-back -> out_data 8'h10..8'h1F in order. First out_valid arrives exactly 2 cycles after the first accept; after that, one word per cycle.
- Same config. Accept sel=3,7,12 on consecutive cycles with out_ready=0 -> in_ready drops to 0 after 2 accepts. out_data=8'h13 holds stable. Raise out_ready -> outputs 8'h13, 8'h17, 8'h1C in order, none lost.
- Bubble test. Accept sel=5, idle one cycle, accept sel=9, with out_ready=0 throughout -> both words are held (bubble collapsed) and in_ready=0. Then out_ready=1 -> 8'h15 then 8'h19 on consecutive cycles.
- Assert rst_n=0 mid-stream with 2 words in flight -> out_valid=0 and out_data=0 immediately (asynchronously). After release with no input, out_valid stays 0 and in_ready=1.
- NUM_IN=32 (odd L=5, S=3) and NUM_IN=2 (S=1), DATA_W=16. Random in_sel and random out_ready over 1000 transfers -> output matches a reference queue. Latency is 3 and 1 cycles respectively when unstalled.
- MUX_TREE_PIPE_SEL_ECHO_EN defined, NUM_IN=16. Send sel=14 -> out_sel=4'hE together with out_data=8'h1E. out_sel holds under stall and is 0 after reset.

Source files
------------

// File: rtl/mux_tree_pipe_if.sv
// Stream bundle for mux_tree_pipe: wide multi-word request side and single-word result side.
// out_sel exists only when MUX_TREE_PIPE_SEL_ECHO_EN is defined.
interface mux_tree_pipe_if #(
    parameter int NUM_IN = 16,
    parameter int DATA_W = 8
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;

`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
    logic [SEL_W-1:0]         out_sel;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );
`else
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
`endif
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_IN:1 word mux as a radix-4 tree, one register stage per 2 select bits, valid/ready both sides.
// Define MUX_TREE_PIPE_SEL_ECHO_EN to carry the full select through the pipe and expose it as out_sel.
module mux_tree_pipe #(
    parameter int NUM_IN = 16,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_tree_pipe_if.slave bus
);
    localparam int SEL_W  = $clog2(NUM_IN);
    localparam int NUM_ST = (SEL_W + 1) / 2;

    // rdy[j] is stage j's ability to load; an empty stage always loads, collapsing bubbles.
    logic [NUM_ST:0] rdy;

    assign rdy[NUM_ST]  = bus.out_ready;
    assign bus.in_ready = rdy[0];

    for (genvar j = 0; j < NUM_ST; j++) begin : g_stage
        localparam int IN_BITS   = SEL_W - 2*j;
        localparam int USE_BITS  = (IN_BITS >= 2) ? 2 : 1;
        localparam int OUT_BITS  = IN_BITS - USE_BITS;
        localparam int IN_WORDS  = NUM_IN >> (2*j);
        localparam int OUT_WORDS = IN_WORDS >> USE_BITS;

        logic [IN_WORDS*DATA_W-1:0]  data_in;
        logic [IN_BITS-1:0]          sel_in;
        logic                        valid_in;
        logic [OUT_WORDS*DATA_W-1:0] mux_d;
        logic [OUT_WORDS*DATA_W-1:0] data_q;
        logic                        v_q;

        assign rdy[j] = !v_q || rdy[j+1];

        if (j == 0) begin : g_src
            assign data_in  = bus.in_data;
            assign valid_in = bus.in_valid && rdy[0];
        end else begin : g_src
            assign data_in  = g_stage[j-1].data_q;
            assign valid_in = g_stage[j-1].v_q;
        end

`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
        logic [SEL_W-1:0] echo_in;
        logic [SEL_W-1:0] echo_q;

        if (j == 0) begin : g_echo_src
            assign echo_in = bus.in_sel;
        end else begin : g_echo_src
            assign echo_in = g_stage[j-1].echo_q;
        end

        // Selection is taken straight from the carried full select.
        assign sel_in = echo_in[SEL_W-1:2*j];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                echo_q <= '0;
            end else if (rdy[j]) begin
                echo_q <= echo_in;
            end
        end
`else
        if (j == 0) begin : g_sel_src
            assign sel_in = bus.in_sel;
        end else begin : g_sel_src
            assign sel_in = g_stage[j-1].g_sel.sel_q;
        end

        // Only the select bits later stages still need are registered.
        if (OUT_BITS > 0) begin : g_sel
            logic [OUT_BITS-1:0] sel_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sel_q <= '0;
                end else if (rdy[j]) begin
                    sel_q <= sel_in[IN_BITS-1:USE_BITS];
                end
            end
        end
`endif

        always_comb begin
            mux_d = '0;
            for (int unsigned w = 0; w < OUT_WORDS; w++) begin
                mux_d[w*DATA_W +: DATA_W] =
                    data_in[((w << USE_BITS) + 32'(sel_in[USE_BITS-1:0])) * DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                v_q    <= 1'b0;
            end else if (rdy[j]) begin
                data_q <= mux_d;
                v_q    <= valid_in;
            end
        end

        if (j == NUM_ST - 1) begin : g_out
            assign bus.out_data  = data_q;
            assign bus.out_valid = v_q;
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
            assign bus.out_sel   = echo_q;
`endif
        end
    end
endmodule
